// File: rtl/pc_gen_pkg.sv
// Shared width/reset defaults plus the next-PC source encoding used by pc_gen.
`ifndef PC_GEN_DEFINES
`define PC_GEN_DEFINES
`define WORD_WIDTH    32
`define PC_RESET_VEC  0
`define RAS_DEPTH_DEF 4
`endif

package pc_gen_pkg;

    typedef enum logic [2:0] {
        SRC_REDIRECT,
        SRC_HOLD,
        SRC_CALL,
        SRC_RET_POP,
        SRC_RET_EMPTY,
        SRC_SEQ
    } pc_src_e;

    // A return with nothing on the stack falls through to sequential fetch.
    function automatic pc_src_e sel_src(input logic redirect,
                                        input logic stall,
                                        input logic call,
                                        input logic ret,
                                        input logic ras_empty);
        if (redirect)  return SRC_REDIRECT;
        if (stall)     return SRC_HOLD;
        if (call)      return SRC_CALL;
        if (ret)       return ras_empty ? SRC_RET_EMPTY : SRC_RET_POP;
        return SRC_SEQ;
    endfunction

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack: a push when full overwrites the oldest entry.
module pc_ras #(
    parameter int WIDTH = `WORD_WIDTH,
    parameter int DEPTH = `RAS_DEPTH_DEF
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] push_data_i,
    output logic [WIDTH-1:0] top_o,
    output logic             empty_o,
    output logic             full_o,
    output logic             ovf_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wp_q, wp_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CW'(DEPTH));
    assign ovf_o   = push_i & full_o;
    assign top_o   = mem_q[wp_q - PW'(1)];

    always_comb begin
        wp_d  = wp_q;
        cnt_d = cnt_q;
        if (push_i) begin
            wp_d = wp_q + PW'(1);
            if (!full_o) cnt_d = cnt_q + CW'(1);
        end else if (pop_i && !empty_o) begin
            wp_d  = wp_q - PW'(1);
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wp_q  <= '0;
            cnt_q <= '0;
        end else begin
            wp_q  <= wp_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage is never reset; the count alone decides what is valid.
    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wp_q] <= push_data_i;
    end

endmodule

// File: rtl/pc_gen.sv
// Fetch PC generator: redirect > stall > call > ret > sequential, with a RAS.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int               WIDTH     = `WORD_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(`PC_RESET_VEC),
    parameter int               STEP      = 1,
    parameter int               RAS_DEPTH = `RAS_DEPTH_DEF
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             stall_i,
    input  logic             redirect_i,
    input  logic [WIDTH-1:0] redirect_pc_i,
    input  logic             call_i,
    input  logic             ret_i,
    input  logic [WIDTH-1:0] target_i,
    output logic [WIDTH-1:0] pc_o,
    output logic             pc_valid_o,
    output logic             ras_empty_o,
    output logic             ras_full_o,
    output logic             ras_ovf_o,
    output logic             ras_unf_o
);

    localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

    logic [WIDTH-1:0] pc_q, pc_d, pc_seq, ras_top;
    logic             valid_q;
    logic             ovf_q, ovf_d, unf_q, unf_d;
    logic             push, pop, ras_empty, ras_full, ras_ovf;
    pc_src_e          src;

    assign pc_seq = pc_q + STEP_W;
    assign src    = sel_src(redirect_i, stall_i, call_i, ret_i, ras_empty);

    pc_ras #(
        .WIDTH (WIDTH),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk_i       (CLK),
        .rst_ni      (RST_N),
        .push_i      (push),
        .pop_i       (pop),
        .push_data_i (pc_seq),
        .top_o       (ras_top),
        .empty_o     (ras_empty),
        .full_o      (ras_full),
        .ovf_o       (ras_ovf)
    );

    always_comb begin
        pc_d  = pc_q;
        push  = 1'b0;
        pop   = 1'b0;
        ovf_d = ovf_q | ras_ovf;
        unf_d = unf_q;
        case (src)
            SRC_REDIRECT:  pc_d = redirect_pc_i;
            SRC_HOLD:      pc_d = pc_q;
            SRC_CALL: begin
                push = 1'b1;
                pc_d = target_i;
            end
            SRC_RET_POP: begin
                pop  = 1'b1;
                pc_d = ras_top;
            end
            SRC_RET_EMPTY: begin
                pc_d  = pc_seq;
                unf_d = 1'b1;
            end
            SRC_SEQ:       pc_d = pc_seq;
            default:       pc_d = pc_q;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pc_q    <= RESET_VEC;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            valid_q <= 1'b1;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign pc_o        = pc_q;
    assign pc_valid_o  = valid_q;
    assign ras_empty_o = ras_empty;
    assign ras_full_o  = ras_full;
    assign ras_ovf_o   = ovf_q;
    assign ras_unf_o   = unf_q;

endmodule

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 Parameter WIDTH, default `WORD_WIDTH, SHALL set the PC and address width in bits.
REQ-002 Parameter RESET_VEC, default 0, SHALL be the PC value loaded on reset.
REQ-003 Parameter STEP, default 1, SHALL be the sequential increment (word addressing).
REQ-004 Parameter RAS_DEPTH, default 4, SHALL set the return-address-stack entry count (power of 2, at least 2).
REQ-005 The port list SHALL be exactly:
- CLK  input  1  single clock; all state updates on posedge.
- RST_N  input  1  asynchronous, active-low reset.
- stall_i  input  1  hold the PC (IF stage blocked).
- redirect_i  input  1  late-stage correction (mispredict or exception).
- redirect_pc_i  input  WIDTH  target for redirect_i.
- call_i  input  1  call decoded at pc_o.
- ret_i  input  1  return decoded at pc_o.
- target_i  input  WIDTH  call target.
- pc_o  output  WIDTH  current PC.
- pc_valid_o  output  1  pc_o is a valid fetch address.
- ras_empty_o  output  1  RAS holds 0 entries.
- ras_full_o  output  1  RAS holds RAS_DEPTH entries.
- ras_ovf_o  output  1  sticky flag: push while full.
- ras_unf_o  output  1  sticky flag: pop while empty.

Function
REQ-006 Next-PC priority per cycle SHALL be: redirect_i > stall_i > call_i > ret_i > sequential.
REQ-007 redirect_i SHALL load pc_o <= redirect_pc_i on the next edge, ignore stall/call/ret that cycle, and leave the RAS unchanged.
REQ-008 stall_i without redirect SHALL hold pc_o and the RAS, and suppress call_i/ret_i.
REQ-009 call_i SHALL push pc_o+STEP onto the RAS and load pc_o <= target_i.
REQ-010 ret_i with a non-empty RAS SHALL load pc_o <= top entry and pop it.
REQ-011 ret_i with an empty RAS SHALL advance pc_o by STEP and set ras_unf_o.
REQ-012 call_i and ret_i together SHALL be treated as call_i only.
REQ-013 A push while full SHALL overwrite the oldest entry (circular buffer), keep the count at RAS_DEPTH, and set ras_ovf_o.
REQ-014 Sequential update SHALL be pc_o <= pc_o+STEP modulo 2^WIDTH; 2^WIDTH-1 SHALL wrap to 0 when STEP=1.
REQ-015 Pushed return addresses SHALL also wrap modulo 2^WIDTH.
REQ-016 pc_valid_o SHALL be 0 in reset and go to 1 on the first posedge after RST_N deasserts, then stay 1.
REQ-017 The RAS count SHALL use clog2(RAS_DEPTH)+1 bits; empty and full flags SHALL be registered-state decodes with no combinational path from the inputs.
REQ-018 Sticky flags SHALL clear only on reset.

Reset
REQ-019 RST_N low SHALL immediately force pc_o=RESET_VEC, pc_valid_o=0, RAS count=0, ras_empty_o=1, ras_full_o=0, ras_ovf_o=0, ras_unf_o=0, regardless of CLK.
REQ-020 RAS storage contents need not be cleared; an empty RAS SHALL never return stale data.
REQ-021 Reset asserted mid-operation, including during a call or stall, SHALL discard all pending state.

Structure
REQ-022 The defaults for WIDTH and RAS_DEPTH and the RESET_VEC value SHALL come from the shared defines.v; no local literal widths.
REQ-023 The return-address stack SHALL be one sub-module, pc_ras, with push, pop, top, empty, full and overflow; pc_gen holds next-PC selection and flags.

Verification (WIDTH=8, STEP=1, RESET_VEC=0, RAS_DEPTH=4)
REQ-024 Release reset, then 5 clocks -> pc_o reads 0,1,2,3,4,5; pc_valid_o is 1 from the first edge.
REQ-025 stall_i high 2 cycles at pc_o=3 -> pc_o holds 3 for both, then 4.
REQ-026 call_i at pc_o=5 with target_i=0x40 -> pc_o=0x40; two clocks later ret_i at 0x42 -> pc_o=6, ras_empty_o=1.
REQ-027 Five calls from pc 0x10,0x20,0x30,0x40,0x50 -> ras_ovf_o=1; four rets -> 0x51,0x41,0x31,0x21; a fifth ret at pc 0x21 -> pc_o=0x22, ras_unf_o=1.
REQ-028 pc_o=0xFF, no controls -> next pc_o=0x00.
REQ-029 redirect_i (0x80) with ret_i and stall_i in the same cycle -> pc_o=0x80, RAS count unchanged; RST_N pulsed low between edges -> pc_o=0 and pc_valid_o=0 before the next edge.
